branch_predictor_table: RTL and testbench

- Parametrised successor to the 32x2-bit branch history table.
- Flop-based table of 2^IDX_W saturating counters with configurable counter width.
- Registered one-cycle lookup; independent same-cycle update port; write-first bypass.
- Optional gshare indexing with a speculative global history register (GHR) and mispredict repair.
- Sits beside the fetch stage: fetch drives the lookup port, execute/branch resolution drives the update port.

---
 rtl/bp_pkg.sv | 35 +++
 rtl/bp_ghr.sv | 35 +++
 rtl/branch_predictor_table.sv | 88 ++++++++
 tb/tb_branch_predictor_table.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and saturating-counter helpers for branch_predictor_table
package bp_pkg;

  localparam int BP_IDX_W_DEF = 5;
  localparam int BP_CTR_W_DEF = 2;
  localparam int CTR_MAX_W    = 4;

  // Reset value: weakly not-taken, one below the taken threshold.
  function automatic logic [CTR_MAX_W-1:0] ctr_init(input int w);
    return CTR_MAX_W'((1 << (w - 1)) - 1);
  endfunction

  // Widened by one bit so the increment at the top never wraps before the clamp.
  function automatic logic [CTR_MAX_W-1:0] ctr_next(input logic [CTR_MAX_W-1:0] ctr,
                                                    input logic taken, input int w);
    logic [CTR_MAX_W:0] ext;
    logic [CTR_MAX_W:0] maxv;
    logic [CTR_MAX_W:0] one;
    one  = {{CTR_MAX_W{1'b0}}, 1'b1};
    maxv = (CTR_MAX_W + 1)'((1 << w) - 1);
    ext  = {1'b0, ctr};
    if (taken) begin
      ext = ext + one;
      if (ext > maxv) ext = maxv;
    end else if (ext != '0) begin
      ext = ext - one;
    end
    return ext[CTR_MAX_W-1:0];
  endfunction

  function automatic logic pred_bit(input logic [CTR_MAX_W-1:0] ctr, input int w);
    return (ctr >> (w - 1)) != '0;
  endfunction

endpackage

// File: rtl/bp_ghr.sv
// rtl/bp_ghr.sv - speculative global history register with mispredict restore (BP_GSHARE_EN builds)
module bp_ghr #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_valid,
  input  logic             shift_taken,
  input  logic             restore_valid,
  input  logic [IDX_W-1:0] restore_ghr,
  input  logic             restore_taken,
  output logic [IDX_W-1:0] ghr
);

  logic [IDX_W-1:0] ghr_next;

  // Truncating the concatenation keeps the low IDX_W bits, which also covers IDX_W=1.
  always_comb begin
    ghr_next = ghr;
    if (restore_valid) begin
      ghr_next = IDX_W'({restore_ghr, restore_taken});
    end else if (shift_valid) begin
      ghr_next = IDX_W'({ghr, shift_taken});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else begin
      ghr <= ghr_next;
    end
  end

endmodule

// File: rtl/branch_predictor_table.sv
// rtl/branch_predictor_table.sv - saturating-counter branch predictor table; BP_GSHARE_EN adds gshare indexing
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W_DEF,
  parameter int CTR_W = BP_CTR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lu_valid,
  input  logic [IDX_W-1:0] lu_addr,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [CTR_W-1:0] pred_ctr,
  output logic [IDX_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_addr,
  input  logic [IDX_W-1:0] upd_ghr,
  input  logic             upd_taken,
  input  logic             upd_mispredict
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

  logic [CTR_W-1:0] table_q [ENTRIES];
  logic [IDX_W-1:0] ghr;
  logic [IDX_W-1:0] lu_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [CTR_W-1:0] upd_new;
  logic [CTR_W-1:0] lu_ctr;
  logic             lu_taken;

`ifdef BP_GSHARE_EN
  bp_ghr #(.IDX_W(IDX_W)) u_ghr (
    .clk           (clk),
    .rst_n         (rst_n),
    .shift_valid   (lu_valid),
    .shift_taken   (lu_taken),
    .restore_valid (upd_valid & upd_mispredict),
    .restore_ghr   (upd_ghr),
    .restore_taken (upd_taken),
    .ghr           (ghr)
  );
  assign lu_idx  = lu_addr ^ ghr;
  assign upd_idx = upd_addr ^ upd_ghr;
`else
  logic unused_gshare_inputs;
  assign unused_gshare_inputs = ^{upd_ghr, upd_mispredict};
  assign ghr     = '0;
  assign lu_idx  = lu_addr;
  assign upd_idx = upd_addr;
`endif

  // Write-first: a same-index update is visible to the lookup in the same cycle.
  always_comb begin
    upd_new  = CTR_W'(ctr_next(CTR_MAX_W'(table_q[upd_idx]), upd_taken, CTR_W));
    lu_ctr   = (upd_valid && (upd_idx == lu_idx)) ? upd_new : table_q[lu_idx];
    lu_taken = pred_bit(CTR_MAX_W'(lu_ctr), CTR_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= CTR_INIT;
      end
    end else if (upd_valid) begin
      table_q[upd_idx] <= upd_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_ctr   <= '0;
      pred_ghr   <= '0;
    end else begin
      pred_valid <= lu_valid;
      if (lu_valid) begin
        pred_taken <= lu_taken;
        pred_ctr   <= lu_ctr;
        pred_ghr   <= ghr;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// tb/tb_branch_predictor_table.sv - randomized self-checking bench for branch_predictor_table against a behavioural model
module tb_branch_predictor_table;

  localparam int IDX_W   = 5;
  localparam int CTR_W   = 2;
  localparam int ENTRIES = 1 << IDX_W;
  localparam int CMAX    = (1 << CTR_W) - 1;
  localparam int CINIT   = (1 << (CTR_W - 1)) - 1;

  logic             clk;
  logic             rst_n;
  logic             lu_valid;
  logic [IDX_W-1:0] lu_addr;
  logic             pred_valid;
  logic             pred_taken;
  logic [CTR_W-1:0] pred_ctr;
  logic [IDX_W-1:0] pred_ghr;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_addr;
  logic [IDX_W-1:0] upd_ghr;
  logic             upd_taken;
  logic             upd_mispredict;

  int tests = 0;
  int fails = 0;
  bit started = 0;

  branch_predictor_table #(.IDX_W(IDX_W), .CTR_W(CTR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lu_valid       (lu_valid),
    .lu_addr        (lu_addr),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_ctr       (pred_ctr),
    .pred_ghr       (pred_ghr),
    .upd_valid      (upd_valid),
    .upd_addr       (upd_addr),
    .upd_ghr        (upd_ghr),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counters as plain integers, GHR as an integer history.
  int m_ctr [ENTRIES];
  int m_ghr;
  int exp_valid, exp_taken, exp_ctr, exp_ghr;
  int li, ui;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) m_ctr[i] = CINIT;
      m_ghr = 0; exp_valid = 0; exp_taken = 0; exp_ctr = 0; exp_ghr = 0;
    end else begin
`ifdef BP_GSHARE_EN
      li = int'(lu_addr) ^ m_ghr;
      ui = int'(upd_addr) ^ int'(upd_ghr);
`else
      li = int'(lu_addr);
      ui = int'(upd_addr);
`endif
      if (upd_valid) begin
        if (upd_taken) m_ctr[ui] = (m_ctr[ui] + 1 > CMAX) ? CMAX : m_ctr[ui] + 1;
        else           m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
      end
      exp_valid = lu_valid;
      if (lu_valid) begin
        exp_ctr   = m_ctr[li];
        exp_taken = (exp_ctr >= (1 << (CTR_W - 1))) ? 1 : 0;
        exp_ghr   = m_ghr;
      end
`ifdef BP_GSHARE_EN
      if (upd_valid && upd_mispredict) m_ghr = ((int'(upd_ghr) << 1) | int'(upd_taken)) % ENTRIES;
      else if (lu_valid)               m_ghr = ((m_ghr << 1) | exp_taken) % ENTRIES;
`endif
    end
  end

  always @(negedge clk) begin
    if (started && rst_n) begin
      check("m_pred_valid", 32'(pred_valid), 32'(exp_valid));
      check("m_pred_ctr",   32'(pred_ctr),   32'(exp_ctr));
      check("m_pred_taken", 32'(pred_taken), 32'(exp_taken));
      check("m_pred_ghr",   32'(pred_ghr),   32'(exp_ghr));
    end
  end

  // Caller sits just after a falling edge; returns just after the next one.
  task automatic step(input logic lv, input int la, input logic uv, input int ua,
                      input logic ut, input logic um, input int ug);
    lu_valid = lv; lu_addr = IDX_W'(la);
    upd_valid = uv; upd_addr = IDX_W'(ua); upd_taken = ut;
    upd_mispredict = um; upd_ghr = IDX_W'(ug);
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rst_valid", 32'(pred_valid), 0);
    check("rst_ctr",   32'(pred_ctr),   0);
    check("rst_taken", 32'(pred_taken), 0);
    check("rst_ghr",   32'(pred_ghr),   0);
    rst_n = 1'b1;
    started = 1;

`ifdef BP_GSHARE_EN
    step(1, 3, 0, 0, 0, 0, 0);
    check("gs_first_ghr", 32'(pred_ghr), 0);
    check("gs_first_ctr", 32'(pred_ctr), 1);
    step(1, 3, 1, 8, 1, 1, 1);
    step(1, 3, 0, 0, 0, 0, 0);
    check("gs_restore_ghr", 32'(pred_ghr), 3);
    check("gs_restore_ctr", 32'(pred_ctr), 1);
`else
    step(1, 5, 0, 0, 0, 0, 0);
    check("lu5_valid", 32'(pred_valid), 1);
    check("lu5_ctr",   32'(pred_ctr),   1);
    check("lu5_taken", 32'(pred_taken), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("idle_valid", 32'(pred_valid), 0);
    check("idle_hold",  32'(pred_ctr),   1);
    repeat (3) step(0, 0, 1, 5, 1, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0);
    check("sat_hi_ctr",   32'(pred_ctr),   3);
    check("sat_hi_taken", 32'(pred_taken), 1);
    repeat (4) step(0, 0, 1, 5, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0);
    check("sat_lo_ctr",   32'(pred_ctr),   0);
    check("sat_lo_taken", 32'(pred_taken), 0);
    step(1, 7, 1, 7, 1, 0, 0);
    check("bypass_ctr",   32'(pred_ctr),   2);
    check("bypass_taken", 32'(pred_taken), 1);
    step(1, 9, 1, 10, 1, 0, 0);
    check("indep_ctr",   32'(pred_ctr),   1);
    check("indep_taken", 32'(pred_taken), 0);
`endif

    for (int n = 0; n < 2000; n++) begin
      logic lv, uv, ut, um;
      int la, ua, ug;
      lv = 1'($urandom_range(0, 1));
      uv = 1'($urandom_range(0, 1));
      ut = 1'($urandom_range(0, 1));
      um = 1'($urandom_range(0, 3) == 0);
      la = (n < 1000) ? $urandom_range(0, 3) : $urandom_range(0, ENTRIES - 1);
      ua = (n < 1000) ? $urandom_range(0, 3) : $urandom_range(0, ENTRIES - 1);
      ug = $urandom_range(0, ENTRIES - 1);
      step(lv, la, uv, ua, ut, um, ug);
    end

    step(0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 1, 2, 1, 0, 0);
    step(0, 0, 1, 3, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(pred_valid), 0);
    check("async_ctr",   32'(pred_ctr),   0);
    check("async_taken", 32'(pred_taken), 0);
    check("async_ghr",   32'(pred_ghr),   0);
    @(negedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int a = 1; a <= 3; a++) begin
      step(1, a, 0, 0, 0, 0, 0);
      check("post_rst_ctr", 32'(pred_ctr), 1);
    end
    step(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
